fixed_point_batch_subtractor: RTL and testbench
===============================================

// Module: fixed_point_batch_subtractor
// PURPOSE
//   Sequential signed fixed-point subtractor for the MID datapath. Loads an initial value,
//   subtracts a batch of streamed operands one per accepted beat, then presents the
//   difference and a sticky overflow flag. Sits after the signed adder stages; uses the
//   same 33-bit overflow rule. Counts the batch down with a narrow decrementing counter.
//   Binary-point position is transparent to this block.
// PARAMETERS
//   WIDTH     32  operand/result width, two's complement
//   CNT_W     3   batch counter width; batch length is 0..2^CNT_W-1
//   SATURATE  1   1: clamp on overflow; 0: wrap (low WIDTH bits kept)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin batch; sampled only in IDLE
//   init_val   in   WIDTH  minuend loaded on start
//   batch_len  in   CNT_W  number of operands to subtract; sampled on start
//   in_valid   in   1      operand valid
//   in_data    in   WIDTH  signed operand (subtrahend)
//   in_ready   out  1      operand accepted when in_valid & in_ready
//   busy       out  1      high in RUN and DONE
//   out_valid  out  1      result valid
//   out_ready  in   1      result consumed when out_valid & out_ready
//   result     out  WIDTH  final difference, registered
//   overflow   out  1      sticky: any step in the batch overflowed
// BEHAVIOUR
//   Reset: state=IDLE, acc=0, cnt=0, ovf=0; in_ready=0, busy=0, out_valid=0, result=0, overflow=0.
//   FSM states: IDLE, RUN, DONE. All outputs are decoded from registered state and registered data.
//   IDLE: in_ready=0. start=1 -> acc<=init_val, cnt<=batch_len, ovf<=0;
//     next state is DONE if batch_len==0, otherwise RUN.
//   RUN: in_ready=1. On each accept: acc<=f(acc-in_data), ovf<=ovf|step_ovf, cnt<=cnt-1.
//     When the accept happens with cnt==1, next state is DONE. in_valid gaps stall the batch
//     with no timeout.
//   DONE: out_valid=1, result=acc, overflow=ovf. Both are stable until out_ready=1,
//     then the next state is IDLE.
//   Arithmetic: diff[WIDTH:0] = {acc[MSB],acc} - {in_data[MSB],in_data};
//     step_ovf = diff[WIDTH] != diff[WIDTH-1].
//     SATURATE=1 with overflow: 0x7FFF..F if diff[WIDTH]==0, else 0x800..0.
//     SATURATE=0, or no overflow: diff[WIDTH-1:0].
//   Latency: out_valid rises on the cycle after the last operand is accepted.
//     For batch_len==0, out_valid rises on the cycle after start.
//   start while busy: ignored; no effect on acc, cnt or ovf.
//   A start in the same cycle as the DONE handshake is ignored. The block is in IDLE on the
//     next cycle, and a new start is accepted from that cycle on.
//   cnt never wraps: decrements only in RUN, and RUN is left when cnt reaches 0.
//   Reset asserted mid-batch returns to IDLE immediately. The partial result is discarded
//     and no out_valid is produced.
// TESTING
//   1 start, init=0x00010000, len=3, operands 0x4000 x3 -> after 3 accepts out_valid=1,
//     result=0x00004000, overflow=0.
//   2 SATURATE=1, init=0x80000000, len=1, operand 0x00000001 -> result=0x80000000, overflow=1.
//     Same stimulus with SATURATE=0 -> result=0x7FFFFFFF, overflow=1.
//   3 init=0x7FFFFFFF, len=2, operands 0xFFFFFFFF then 0x00000001 ->
//     SATURATE=1: result=0x7FFFFFFE, overflow=1 (sticky despite later in-range step).
//   4 len=0, init=0x12345678 -> out_valid the cycle after start, result=0x12345678,
//     overflow=0, in_ready never high.
//   5 out_ready held low 5 cycles with start pulses and in_valid toggling -> result, overflow
//     and out_valid stable, in_ready=0. Release -> IDLE next cycle; the next start is accepted.
//   6 len=7 with in_valid gaps, rst_n pulsed low after 4 accepts -> all outputs 0 while in
//     reset. A fresh batch after reset completes normally with correct cnt.

Source files
------------

// File: rtl/fixed_point_batch_subtractor.sv
// Sequential signed subtractor: loads a minuend, subtracts a counted batch of streamed
// operands with saturate-or-wrap handling, then holds the result and a sticky overflow flag.
module fixed_point_batch_subtractor #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_W    = 3,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] init_val,
  input  logic [CNT_W-1:0] batch_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   diff;
  logic             step_ovf;
  logic [WIDTH-1:0] step_res;

  // One guard bit above the operands: overflow shows as a mismatch of the top two bits.
  always_comb begin
    diff     = {acc_q[WIDTH-1], acc_q} - {in_data[WIDTH-1], in_data};
    step_ovf = diff[WIDTH] ^ diff[WIDTH-1];
    if (SATURATE && step_ovf) begin
      step_res = diff[WIDTH] ? MinNeg : MaxPos;
    end else begin
      step_res = diff[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = init_val;
          cnt_d   = batch_len;
          ovf_d   = 1'b0;
          state_d = (batch_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (in_valid) begin
          acc_d = step_res;
          ovf_d = ovf_q | step_ovf;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result and flag are only presented in DONE so partial sums never leak out.
  assign in_ready  = (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = (state_q == StDone) ? acc_q : '0;
  assign overflow  = (state_q == StDone) & ovf_q;

endmodule

// File: tb/tb_fixed_point_batch_subtractor.sv
// Bench for fixed_point_batch_subtractor: saturating and wrapping instances share stimulus,
// checked against hand vectors and a plain-integer reference model.
module tb_fixed_point_batch_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] init_val = '0;
  logic [2:0]  batch_len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_s, busy_s, out_valid_s, overflow_s;
  logic [31:0] result_s;
  logic        in_ready_w, busy_w, out_valid_w, overflow_w;
  logic [31:0] result_w;

  int checks = 0;
  int errors = 0;

  logic [31:0] op_tab [7];

  always #5 clk = ~clk;

  fixed_point_batch_subtractor #(.WIDTH(32), .CNT_W(3), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .init_val(init_val), .batch_len(batch_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s), .busy(busy_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s), .overflow(overflow_s)
  );

  fixed_point_batch_subtractor #(.WIDTH(32), .CNT_W(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .init_val(init_val), .batch_len(batch_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w), .busy(busy_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w), .overflow(overflow_w)
  );

  typedef struct {
    string       name;
    logic [31:0] init;
    int          len;
    logic [31:0] ops [7];
    logic [31:0] exp_s;
    logic        ovf_s;
    logic [31:0] exp_w;
    logic        ovf_w;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed integer model: subtract with exact arithmetic, then clamp or wrap on overflow.
  task automatic ref_model(input logic [31:0] init, input int n, input bit sat,
                           output logic [31:0] res, output logic ovf);
    longint a;
    longint d;
    logic [63:0] dbits;
    a   = longint'($signed(init));
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = a - longint'($signed(op_tab[i]));
      if (d > 64'sd2147483647 || d < -64'sd2147483648) begin
        ovf = 1'b1;
        if (sat) begin
          a = (d > 0) ? 64'sd2147483647 : -64'sd2147483648;
        end else begin
          dbits = d;
          a = longint'($signed(dbits[31:0]));
        end
      end else begin
        a = d;
      end
    end
    dbits = a;
    res = dbits[31:0];
  endtask

  task automatic do_batch(input string name, input logic [31:0] init, input int len,
                          input logic [31:0] es, input logic eos,
                          input logic [31:0] ew, input logic eow, input bit gaps);
    @(posedge clk); #1;
    start = 1'b1; init_val = init; batch_len = 3'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (len == 0) begin
      chk({name, "_len0_in_ready"}, {31'b0, in_ready_s}, 32'd0);
    end
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          start    = 1'($urandom_range(0, 1));
          init_val = $urandom;
          @(posedge clk); #1;
          start = 1'b0;
          chk({name, "_gap_busy"}, {31'b0, busy_s}, 32'd1);
          chk({name, "_gap_out_valid"}, {31'b0, out_valid_w}, 32'd0);
        end
      end
      in_valid = 1'b1;
      in_data  = op_tab[i];
      chk({name, "_in_ready"}, {31'b0, in_ready_s}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    chk({name, "_out_valid_s"}, {31'b0, out_valid_s}, 32'd1);
    chk({name, "_out_valid_w"}, {31'b0, out_valid_w}, 32'd1);
    chk({name, "_done_in_ready"}, {31'b0, in_ready_w}, 32'd0);
    chk({name, "_result_s"}, result_s, es);
    chk({name, "_overflow_s"}, {31'b0, overflow_s}, {31'b0, eos});
    chk({name, "_result_w"}, result_w, ew);
    chk({name, "_overflow_w"}, {31'b0, overflow_w}, {31'b0, eow});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_release_out_valid"}, {31'b0, out_valid_s}, 32'd0);
    chk({name, "_release_busy"}, {31'b0, busy_w}, 32'd0);
  endtask

  initial begin
    logic [31:0] rs, rw;
    logic        os, ow;
    int          len;
    logic [31:0] init;

    vecs[0].name = "v1_basic";  vecs[0].init = 32'h0001_0000; vecs[0].len = 3;
    vecs[0].ops  = '{32'h4000, 32'h4000, 32'h4000, 0, 0, 0, 0};
    vecs[0].exp_s = 32'h0000_4000; vecs[0].ovf_s = 1'b0;
    vecs[0].exp_w = 32'h0000_4000; vecs[0].ovf_w = 1'b0;
    vecs[1].name = "v2_negovf"; vecs[1].init = 32'h8000_0000; vecs[1].len = 1;
    vecs[1].ops  = '{32'h1, 0, 0, 0, 0, 0, 0};
    vecs[1].exp_s = 32'h8000_0000; vecs[1].ovf_s = 1'b1;
    vecs[1].exp_w = 32'h7FFF_FFFF; vecs[1].ovf_w = 1'b1;
    vecs[2].name = "v3_sticky"; vecs[2].init = 32'h7FFF_FFFF; vecs[2].len = 2;
    vecs[2].ops  = '{32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0};
    vecs[2].exp_s = 32'h7FFF_FFFE; vecs[2].ovf_s = 1'b1;
    vecs[2].exp_w = 32'h7FFF_FFFF; vecs[2].ovf_w = 1'b1;
    vecs[3].name = "v4_len0";   vecs[3].init = 32'h1234_5678; vecs[3].len = 0;
    vecs[3].ops  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[3].exp_s = 32'h1234_5678; vecs[3].ovf_s = 1'b0;
    vecs[3].exp_w = 32'h1234_5678; vecs[3].ovf_w = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", {31'b0, in_ready_s}, 32'd0);
    chk("rst_busy", {31'b0, busy_s}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid_w}, 32'd0);
    chk("rst_result", result_s, 32'd0);
    chk("rst_overflow", {31'b0, overflow_w}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      op_tab = vecs[v].ops;
      do_batch(vecs[v].name, vecs[v].init, vecs[v].len,
               vecs[v].exp_s, vecs[v].ovf_s, vecs[v].exp_w, vecs[v].ovf_w, 1'b0);
    end

    // Randomized batches with gaps and ignored starts, against the model
    for (int r = 0; r < 25; r++) begin
      len  = $urandom_range(0, 7);
      init = ($urandom_range(0, 2) == 0) ? 32'h7FFF_FFF0 : $urandom;
      for (int i = 0; i < 7; i++) begin
        case ($urandom_range(0, 4))
          0: op_tab[i] = 32'h7FFF_FFFF;
          1: op_tab[i] = 32'h8000_0000;
          2: op_tab[i] = 32'hFFFF_FFFF;
          default: op_tab[i] = $urandom;
        endcase
      end
      ref_model(init, len, 1'b1, rs, os);
      ref_model(init, len, 1'b0, rw, ow);
      do_batch("rand", init, len, rs, os, rw, ow, 1'b1);
    end

    // Output held under back-pressure while start and in_valid toggle
    op_tab[0] = 32'd3;
    @(posedge clk); #1;
    start = 1'b1; init_val = 32'd5; batch_len = 3'd1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = op_tab[0];
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      start    = ~start;
      in_valid = ~in_valid;
      init_val = $urandom;
      in_data  = $urandom;
      batch_len = 3'd0;
      chk("hold_out_valid", {31'b0, out_valid_s}, 32'd1);
      chk("hold_result", result_s, 32'd2);
      chk("hold_overflow", {31'b0, overflow_s}, 32'd0);
      chk("hold_in_ready", {31'b0, in_ready_w}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b1; init_val = 32'd100; batch_len = 3'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    chk("handshake_start_ignored_busy", {31'b0, busy_s}, 32'd0);
    chk("handshake_start_ignored_valid", {31'b0, out_valid_w}, 32'd0);
    do_batch("after_hold", 32'h0000_0055, 0, 32'h55, 1'b0, 32'h55, 1'b0, 1'b0);

    // Reset in the middle of a 7-operand batch
    for (int i = 0; i < 7; i++) op_tab[i] = 32'd10;
    @(posedge clk); #1;
    start = 1'b1; init_val = 32'd1000; batch_len = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = op_tab[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready_s}, 32'd0);
    chk("midrst_busy", {31'b0, busy_w}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid_s}, 32'd0);
    chk("midrst_result", result_w, 32'd0);
    chk("midrst_overflow", {31'b0, overflow_s}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_hold_valid", {31'b0, out_valid_w}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_idle", {31'b0, busy_s}, 32'd0);
    op_tab[0] = 32'h0000_0100; op_tab[1] = 32'h0000_0200; op_tab[2] = 32'h0000_0300;
    ref_model(32'h0000_1000, 3, 1'b1, rs, os);
    ref_model(32'h0000_1000, 3, 1'b0, rw, ow);
    do_batch("post_reset", 32'h0000_1000, 3, rs, os, rw, ow, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
